// File: rtl/seq_control_pkg.sv
// seq_control_pkg: opcode map, EXT sub-ops, ALU codes and
// sequencer states shared by seq_control and its bench.
package seq_control_pkg;

  localparam logic [3:0] OP_EXT  = 4'h0;
  localparam logic [3:0] OP_MOVI = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_XORI = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [3:0] OP_JZ   = 4'h5;
  localparam logic [3:0] OP_MOVR = 4'h6;
  localparam logic [3:0] OP_ADDR = 4'h7;
  localparam logic [3:0] OP_SUBR = 4'h8;
  localparam logic [3:0] OP_ANDR = 4'h9;
  localparam logic [3:0] OP_ORR  = 4'hA;
  localparam logic [3:0] OP_XORR = 4'hB;
  localparam logic [3:0] OP_CMPR = 4'hC;
  localparam logic [3:0] OP_JNZ  = 4'hD;
  localparam logic [3:0] OP_SUBI = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam logic [3:0] EXT_NOP   = 4'h0;
  localparam logic [3:0] EXT_SHLI  = 4'h1;
  localparam logic [3:0] EXT_SHRI  = 4'h2;
  localparam logic [3:0] EXT_SHLR  = 4'h3;
  localparam logic [3:0] EXT_SHRR  = 4'h4;
  localparam logic [3:0] EXT_RET   = 4'h5;
  localparam logic [3:0] EXT_CALLR = 4'h6;

  localparam logic [2:0] ALU_OP_ADD   = 3'd0;
  localparam logic [2:0] ALU_OP_SUB   = 3'd1;
  localparam logic [2:0] ALU_OP_AND   = 3'd2;
  localparam logic [2:0] ALU_OP_OR    = 3'd3;
  localparam logic [2:0] ALU_OP_XOR   = 3'd4;
  localparam logic [2:0] ALU_OP_PASSB = 3'd5;
  localparam logic [2:0] ALU_OP_SHL   = 3'd6;
  localparam logic [2:0] ALU_OP_SHR   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_HALTED
  } state_e;

endpackage

// File: rtl/seq_control_ret_stack.sv
// ret_stack: bounded LIFO of return addresses.
// Ports: push_i/pop_i/data_i in; top_o/full_o/empty_o out.
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] top_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int SPW = $clog2(DEPTH + 1);

  logic [SPW-1:0] sp_q, sp_d;
  logic [W-1:0]   mem_q [DEPTH];

  assign full_o  = (sp_q == SPW'(DEPTH));
  assign empty_o = (sp_q == '0);

  always_comb begin
    sp_d = sp_q;
    if (push_i && !full_o)
      sp_d = sp_q + SPW'(1);
    else if (pop_i && !empty_o)
      sp_d = sp_q - SPW'(1);
  end

  // top is the entry just below sp
  always_comb begin
    top_o = '0;
    for (int i = 0; i < DEPTH; i++)
      if (sp_q == SPW'(i + 1))
        top_o = mem_q[i];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sp_q <= '0;
    else        sp_q <= sp_d;
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o)
      for (int i = 0; i < DEPTH; i++)
        if (sp_q == SPW'(i))
          mem_q[i] <= data_i;
  end

endmodule

// File: rtl/seq_control.sv
// seq_control: multi-cycle fetch/exec sequencer; owns PC,
// drives one-cycle RF/ALU/flag strobes in EXEC.
// Ports: clk,rst_n,run; imem_req/addr/valid/rdata; flag_z/c/s;
// rf_rdata_b; pc, reg_we, rf_*addr*, alu_b_sel, alu_op, imm,
// flags_we, retired, halt, fault.
// Macro SEQ_CONTROL_STACK_EN enables CALLR/RET + ret_stack.
module seq_control
  import seq_control_pkg::*;
#(
  parameter int PC_W        = 8,
  parameter int RF_AW       = 2,
  parameter int IMM_W       = 8,
  parameter int STACK_DEPTH = 4,
  localparam int INSN_W     = 4 + 2 * RF_AW + IMM_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_valid,
  input  logic [INSN_W-1:0] imem_rdata,
  input  logic              flag_z,
  input  logic              flag_c,
  input  logic              flag_s,
  input  logic [PC_W-1:0]   rf_rdata_b,
  output logic [PC_W-1:0]   pc,
  output logic              reg_we,
  output logic [RF_AW-1:0]  rf_waddr,
  output logic [RF_AW-1:0]  rf_raddr_a,
  output logic [RF_AW-1:0]  rf_raddr_b,
  output logic              alu_b_sel,
  output logic [2:0]        alu_op,
  output logic [IMM_W-1:0]  imm,
  output logic [2:0]        flags_we,
  output logic              retired,
  output logic              halt,
  output logic              fault
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [INSN_W-1:0] ir_q, ir_d;
  logic              halt_q, halt_d;
  logic              fault_q, fault_d;

  logic [3:0]        op, sub;
  logic [PC_W-1:0]   pc_inc, jmp_tgt;
  logic              dec_we, dec_fl;
  logic              dec_jmp, dec_hlt;
  logic              stk_hit, stk_err;
  logic [PC_W-1:0]   stk_tgt;
  logic              unused_flags;

  assign op         = ir_q[INSN_W-1 -: 4];
  assign rf_waddr   = ir_q[INSN_W-5 -: RF_AW];
  assign rf_raddr_a = rf_waddr;
  assign rf_raddr_b = ir_q[IMM_W +: RF_AW];
  assign imm        = ir_q[IMM_W-1:0];
  assign sub        = imm[IMM_W-1 -: 4];

  assign pc_inc     = pc_q + PC_W'(1);
  assign jmp_tgt    = PC_W'(imm);
  assign pc         = pc_q;
  assign imem_addr  = pc_q;
  assign halt       = halt_q;
  assign fault      = fault_q;

  assign unused_flags = flag_c ^ flag_s;

  always_comb begin
    alu_op    = ALU_OP_ADD;
    alu_b_sel = 1'b0;
    dec_we    = 1'b0;
    dec_fl    = 1'b0;
    dec_jmp   = 1'b0;
    dec_hlt   = 1'b0;
    case (op)
      OP_EXT: begin
        case (sub)
          EXT_SHLI: begin
            dec_we = 1'b1; dec_fl = 1'b1;
            alu_op = ALU_OP_SHL;
          end
          EXT_SHRI: begin
            dec_we = 1'b1; dec_fl = 1'b1;
            alu_op = ALU_OP_SHR;
          end
          EXT_SHLR: begin
            dec_we = 1'b1; dec_fl = 1'b1;
            alu_op = ALU_OP_SHL; alu_b_sel = 1'b1;
          end
          EXT_SHRR: begin
            dec_we = 1'b1; dec_fl = 1'b1;
            alu_op = ALU_OP_SHR; alu_b_sel = 1'b1;
          end
          EXT_NOP, EXT_RET, EXT_CALLR: ;
          default: ;
        endcase
      end
      OP_MOVI: begin
        dec_we = 1'b1; alu_op = ALU_OP_PASSB;
      end
      OP_ADDI: begin
        dec_we = 1'b1; dec_fl = 1'b1;
        alu_op = ALU_OP_ADD;
      end
      OP_XORI: begin
        dec_we = 1'b1; dec_fl = 1'b1;
        alu_op = ALU_OP_XOR;
      end
      OP_JMP: dec_jmp = 1'b1;
      OP_JZ:  dec_jmp = flag_z;
      OP_JNZ: dec_jmp = !flag_z;
      OP_MOVR: begin
        dec_we = 1'b1; alu_b_sel = 1'b1;
        alu_op = ALU_OP_PASSB;
      end
      OP_ADDR: begin
        dec_we = 1'b1; dec_fl = 1'b1;
        alu_b_sel = 1'b1; alu_op = ALU_OP_ADD;
      end
      OP_SUBR: begin
        dec_we = 1'b1; dec_fl = 1'b1;
        alu_b_sel = 1'b1; alu_op = ALU_OP_SUB;
      end
      OP_ANDR: begin
        dec_we = 1'b1; dec_fl = 1'b1;
        alu_b_sel = 1'b1; alu_op = ALU_OP_AND;
      end
      OP_ORR: begin
        dec_we = 1'b1; dec_fl = 1'b1;
        alu_b_sel = 1'b1; alu_op = ALU_OP_OR;
      end
      OP_XORR: begin
        dec_we = 1'b1; dec_fl = 1'b1;
        alu_b_sel = 1'b1; alu_op = ALU_OP_XOR;
      end
      OP_CMPR: begin
        dec_fl = 1'b1;
        alu_b_sel = 1'b1; alu_op = ALU_OP_SUB;
      end
      OP_SUBI: begin
        dec_we = 1'b1; dec_fl = 1'b1;
        alu_op = ALU_OP_SUB;
      end
      OP_HLT: dec_hlt = 1'b1;
    endcase
  end

`ifdef SEQ_CONTROL_STACK_EN
  logic            stk_push, stk_pop;
  logic            stk_full, stk_empty;
  logic [PC_W-1:0] stk_top;

  ret_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (PC_W)
  ) u_ret_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (stk_push),
    .pop_i   (stk_pop),
    .data_i  (pc_inc),
    .top_o   (stk_top),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );

  // a blocked push/pop becomes a fault and leaves sp alone
  always_comb begin
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    stk_hit  = 1'b0;
    stk_err  = 1'b0;
    stk_tgt  = pc_q;
    if (state_q == ST_EXEC && op == OP_EXT) begin
      if (sub == EXT_CALLR) begin
        stk_hit  = 1'b1;
        stk_err  = stk_full;
        stk_push = !stk_full;
        stk_tgt  = rf_rdata_b;
      end else if (sub == EXT_RET) begin
        stk_hit  = 1'b1;
        stk_err  = stk_empty;
        stk_pop  = !stk_empty;
        stk_tgt  = stk_top;
      end
    end
  end
`else
  logic unused_stk;
  localparam int unused_depth = STACK_DEPTH;

  assign stk_hit    = 1'b0;
  assign stk_err    = 1'b0;
  assign stk_tgt    = pc_q;
  assign unused_stk = ^rf_rdata_b;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    halt_d   = halt_q;
    fault_d  = fault_q;
    imem_req = 1'b0;
    retired  = 1'b0;
    reg_we   = 1'b0;
    flags_we = 3'b000;
    unique case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) begin
          ir_d    = imem_rdata;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (stk_err) begin
          fault_d = 1'b1;
          halt_d  = 1'b1;
          state_d = ST_HALTED;
        end else if (dec_hlt) begin
          halt_d  = 1'b1;
          retired = 1'b1;
          state_d = ST_HALTED;
        end else begin
          retired  = 1'b1;
          reg_we   = dec_we;
          flags_we = {3{dec_fl}};
          state_d  = ST_FETCH;
          if (stk_hit)      pc_d = stk_tgt;
          else if (dec_jmp) pc_d = jmp_tgt;
          else              pc_d = pc_inc;
        end
      end
      ST_HALTED: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      halt_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      halt_q  <= halt_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: tb/tb_seq_control.sv
// tb_seq_control: directed + random instruction streams
// checked against an ISA-level model of the sequencer.
module tb_seq_control;

  localparam int PC_W   = 8;
  localparam int RF_AW  = 2;
  localparam int IMM_W  = 8;
  localparam int DEPTH  = 4;
  localparam int INSN_W = 16;

`ifdef SEQ_CONTROL_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              run = 1'b0;
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_valid = 1'b0;
  logic [INSN_W-1:0] imem_rdata = '0;
  logic              flag_z = 1'b0;
  logic              flag_c = 1'b0;
  logic              flag_s = 1'b0;
  logic [PC_W-1:0]   rf_rdata_b = '0;
  logic [PC_W-1:0]   pc;
  logic              reg_we;
  logic [RF_AW-1:0]  rf_waddr, rf_raddr_a, rf_raddr_b;
  logic              alu_b_sel;
  logic [2:0]        alu_op;
  logic [IMM_W-1:0]  imm;
  logic [2:0]        flags_we;
  logic              retired, halt, fault;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] m_pc;
  logic [7:0] m_stk[$];

  always #5 clk = ~clk;

  seq_control #(
    .PC_W(PC_W), .RF_AW(RF_AW),
    .IMM_W(IMM_W), .STACK_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .flag_z(flag_z), .flag_c(flag_c), .flag_s(flag_s),
    .rf_rdata_b(rf_rdata_b), .pc(pc), .reg_we(reg_we),
    .rf_waddr(rf_waddr), .rf_raddr_a(rf_raddr_a),
    .rf_raddr_b(rf_raddr_b), .alu_b_sel(alu_b_sel),
    .alu_op(alu_op), .imm(imm), .flags_we(flags_we),
    .retired(retired), .halt(halt), .fault(fault)
  );

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; imem_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    n_cmp++;
    if ({pc, imem_req, retired, reg_we, flags_we,
         halt, fault} !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_outs got pc=%h req=%b ret=%b we=%b fw=%b h=%b f=%b want all 0",
               pc, imem_req, retired, reg_we, flags_we, halt, fault);
    end
    rst_n = 1'b1;
    m_pc = 8'h00;
    m_stk.delete();
    @(negedge clk);
  endtask

  task automatic start_run();
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  // feeds one instruction through FETCH/EXEC and checks it
  task automatic drive_insn(input logic [15:0] insn,
                            input int dly,
                            input logic fz,
                            input logic [7:0] rfb);
    logic [3:0] op, sub;
    logic [1:0] dst, src;
    logic [7:0] im, npc;
    logic [2:0] aop;
    bit we, fl, bsel, hlt, flt;
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== m_pc ||
        retired !== 1'b0) begin
      n_bad++;
      $display("FAIL fetch_start got req=%b addr=%h ret=%b want 1 %h 0",
               imem_req, imem_addr, retired, m_pc);
    end
    flag_z = fz;
    rf_rdata_b = rfb;
    for (int i = 0; i < dly; i++) begin
      imem_valid = 1'b0;
      imem_rdata = 16'($urandom);
      @(negedge clk);
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== m_pc ||
          retired !== 1'b0) begin
        n_bad++;
        $display("FAIL fetch_hold got req=%b addr=%h ret=%b want 1 %h 0",
                 imem_req, imem_addr, retired, m_pc);
      end
    end
    imem_valid = 1'b1;
    imem_rdata = insn;
    @(negedge clk);
    imem_valid = 1'($urandom);
    imem_rdata = 16'($urandom);

    op = insn[15:12]; dst = insn[11:10];
    src = insn[9:8]; im = insn[7:0]; sub = im[7:4];
    we = 0; fl = 0; bsel = 0; hlt = 0; flt = 0;
    aop = 3'd0;
    npc = m_pc + 8'd1;
    case (op)
      4'h0: case (sub)
        4'h1: begin we = 1; fl = 1; aop = 3'd6; end
        4'h2: begin we = 1; fl = 1; aop = 3'd7; end
        4'h3: begin we = 1; fl = 1; aop = 3'd6; bsel = 1; end
        4'h4: begin we = 1; fl = 1; aop = 3'd7; bsel = 1; end
        4'h5: if (STK) begin
          if (m_stk.size() == 0) flt = 1;
          else npc = m_stk.pop_back();
        end
        4'h6: if (STK) begin
          if (m_stk.size() == DEPTH) flt = 1;
          else begin
            m_stk.push_back(m_pc + 8'd1);
            npc = rfb;
          end
        end
        default: ;
      endcase
      4'h1: begin we = 1; aop = 3'd5; end
      4'h2: begin we = 1; fl = 1; aop = 3'd0; end
      4'h3: begin we = 1; fl = 1; aop = 3'd4; end
      4'h4: npc = im;
      4'h5: if (fz) npc = im;
      4'h6: begin we = 1; aop = 3'd5; bsel = 1; end
      4'h7: begin we = 1; fl = 1; aop = 3'd0; bsel = 1; end
      4'h8: begin we = 1; fl = 1; aop = 3'd1; bsel = 1; end
      4'h9: begin we = 1; fl = 1; aop = 3'd2; bsel = 1; end
      4'hA: begin we = 1; fl = 1; aop = 3'd3; bsel = 1; end
      4'hB: begin we = 1; fl = 1; aop = 3'd4; bsel = 1; end
      4'hC: begin fl = 1; aop = 3'd1; bsel = 1; end
      4'hD: if (!fz) npc = im;
      4'hE: begin we = 1; fl = 1; aop = 3'd1; end
      4'hF: hlt = 1;
    endcase
    if (hlt || flt) npc = m_pc;

    n_cmp++;
    if (retired !== !flt || reg_we !== we ||
        flags_we !== {3{fl}}) begin
      n_bad++;
      $display("FAIL exec_strobe insn=%h got ret=%b we=%b fw=%b want %b %b %b",
               insn, retired, reg_we, flags_we, !flt, we, {3{fl}});
    end
    n_cmp++;
    if (rf_waddr !== dst || rf_raddr_a !== dst ||
        rf_raddr_b !== src || imm !== im) begin
      n_bad++;
      $display("FAIL exec_fields insn=%h got wa=%h ra=%h rb=%h imm=%h",
               insn, rf_waddr, rf_raddr_a, rf_raddr_b, imm);
    end
    if (we || fl) begin
      n_cmp++;
      if (alu_op !== aop || alu_b_sel !== bsel) begin
        n_bad++;
        $display("FAIL exec_alu insn=%h got op=%0d bsel=%b want %0d %b",
                 insn, alu_op, alu_b_sel, aop, bsel);
      end
    end
    @(negedge clk);
    imem_valid = 1'b0;
    n_cmp++;
    if (pc !== npc || halt !== (hlt || flt) ||
        fault !== flt) begin
      n_bad++;
      $display("FAIL next_pc insn=%h got pc=%h h=%b f=%b want %h %b %b",
               insn, pc, halt, fault, npc, hlt || flt, flt);
    end
    m_pc = npc;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b0 || pc !== 8'h00) begin
      n_bad++;
      $display("FAIL idle_no_run got req=%b pc=%h want 0 00",
               imem_req, pc);
    end
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    start_run();
    drive_insn(16'h4040, 1, 1'b0, 8'h00);
    imem_valid = 1'b1;
    imem_rdata = 16'h1405;
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (pc !== 8'h00 || imem_req !== 1'b0 ||
        retired !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_fetch got pc=%h req=%b ret=%b want 00 0 0",
               pc, imem_req, retired);
    end
    rst_n = 1'b1;
    imem_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b0 || retired !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset_idle got req=%b ret=%b want 0 0",
               imem_req, retired);
    end
  endtask

  task automatic test_basic();
    do_reset();
    start_run();
    drive_insn(16'h1405, 0, 1'b0, 8'h00);
    drive_insn(16'h24FF, 0, 1'b0, 8'h00);
    drive_insn(16'h5010, 0, 1'b0, 8'h00);
    n_cmp++;
    if (pc !== 8'h03) begin
      n_bad++;
      $display("FAIL basic_pc got %h want 03", pc);
    end
  endtask

  task automatic test_delay();
    do_reset();
    start_run();
    drive_insn(16'h1405, 3, 1'b0, 8'h00);
    drive_insn(16'h7600, 2, 1'b1, 8'h00);
  endtask

  task automatic test_wrap();
    do_reset();
    start_run();
    drive_insn(16'h40FF, 0, 1'b0, 8'h00);
    drive_insn(16'h0000, 1, 1'b0, 8'h00);
    n_cmp++;
    if (pc !== 8'h00) begin
      n_bad++;
      $display("FAIL pc_wrap got %h want 00", pc);
    end
  endtask

  task automatic test_random();
    logic [15:0] w;
    do_reset();
    start_run();
    for (int k = 0; k < 200; k++) begin
      w = 16'($urandom);
      if (w[15:12] == 4'hF) w[15:12] = 4'h2;
      if (STK && w[15:12] == 4'h0 &&
          (w[7:4] == 4'h5 || w[7:4] == 4'h6))
        w[7:4] = 4'h0;
      drive_insn(w, $urandom_range(0, 3),
                 1'($urandom), 8'($urandom));
    end
  endtask

`ifdef SEQ_CONTROL_STACK_EN
  task automatic test_stack();
    do_reset();
    start_run();
    for (int k = 0; k < 4; k++)
      drive_insn(16'h0260, 0, 1'b0, 8'h20);
    drive_insn(16'h0050, 0, 1'b0, 8'h00);
    n_cmp++;
    if (pc !== 8'h21) begin
      n_bad++;
      $display("FAIL ret_target got %h want 21", pc);
    end
    drive_insn(16'h0260, 1, 1'b0, 8'h20);
    drive_insn(16'h0260, 0, 1'b0, 8'h20);
    n_cmp++;
    if (fault !== 1'b1 || halt !== 1'b1 ||
        pc !== 8'h20) begin
      n_bad++;
      $display("FAIL overflow got f=%b h=%b pc=%h want 1 1 20",
               fault, halt, pc);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    start_run();
    drive_insn(16'h0050, 0, 1'b0, 8'h00);
    n_cmp++;
    if (fault !== 1'b1 || pc !== 8'h00) begin
      n_bad++;
      $display("FAIL underflow got f=%b pc=%h want 1 00",
               fault, pc);
    end
  endtask
`else
  task automatic test_ext_nop();
    do_reset();
    start_run();
    drive_insn(16'h0260, 0, 1'b0, 8'h20);
    drive_insn(16'h0050, 0, 1'b0, 8'h00);
    n_cmp++;
    if (pc !== 8'h02 || fault !== 1'b0) begin
      n_bad++;
      $display("FAIL ext_nop got pc=%h f=%b want 02 0",
               pc, fault);
    end
  endtask
`endif

  task automatic test_hlt();
    do_reset();
    start_run();
    drive_insn(16'h1405, 0, 1'b0, 8'h00);
    drive_insn(16'hF123, 0, 1'b0, 8'h00);
    run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      imem_valid = 1'($urandom);
      @(negedge clk);
      n_cmp++;
      if (imem_req !== 1'b0 || retired !== 1'b0 ||
          halt !== 1'b1 || fault !== 1'b0 ||
          pc !== 8'h01) begin
        n_bad++;
        $display("FAIL halted got req=%b ret=%b h=%b f=%b pc=%h",
                 imem_req, retired, halt, fault, pc);
      end
    end
    run = 1'b0;
    imem_valid = 1'b0;
    do_reset();
  endtask

  initial begin
    test_reset();
    test_reset_mid_fetch();
    test_basic();
    test_delay();
    test_wrap();
    test_random();
`ifdef SEQ_CONTROL_STACK_EN
    test_stack();
    test_underflow();
`else
    test_ext_nop();
`endif
    test_hlt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
